// File: rtl/blink_pattern_gen.sv
// LED pattern generator: OFF / BLINK / CHASE / BOUNCE with prescaled step rate and valid/ready config.
// Optional LED_PWM_EN adds cfg_bright and a free-running PWM gate on the LED outputs.
//
// state | meaning
// RUN   | patterns advance on step ticks, config can be accepted
// APPLY | one cycle: restart timers and load the initial pattern of the new mode

module blink_pattern_gen #(
  parameter int         CLK_FREQ   = 25_000_000,
  parameter int         TICK_HZ    = 2,
  parameter int         NUM_LEDS   = 8,
  parameter logic [1:0] RESET_MODE = 2'd1,
  parameter int         PWM_BITS   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_mode,
  input  logic [3:0]          cfg_speed,
`ifdef LED_PWM_EN
  input  logic [PWM_BITS-1:0] cfg_bright,
`endif
  output logic                tick_o,
  output logic [NUM_LEDS-1:0] leds
);

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]    TICK_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [NUM_LEDS-1:0] ONE_HOT0   = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] BLINK_MASK = ONE_HOT0 | (ONE_HOT0 << (NUM_LEDS - 1));

  typedef enum logic {RUN = 1'b0, APPLY = 1'b1} state_t;
  typedef enum logic [1:0] {M_OFF = 2'd0, M_BLINK = 2'd1, M_CHASE = 2'd2, M_BOUNCE = 2'd3} mode_t;

  state_t              state;
  logic [1:0]          mode;
  logic [3:0]          speed;
  logic [3:0]          step_cnt;
  logic [PRE_W-1:0]    prescaler;
  logic                dir;
  logic [NUM_LEDS-1:0] pattern;
  logic [NUM_LEDS-1:0] next_pattern;
  logic [NUM_LEDS-1:0] init_pattern;
  logic                next_dir;
  logic                tick;

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] bright;
  logic [PWM_BITS-1:0] pwm_cnt;
`endif

  assign cfg_ready = (state == RUN);
  assign tick      = (state == RUN) && (prescaler == TICK_LAST);
  assign tick_o    = tick;

  // dir: 0 = toward MSB, 1 = toward bit0
  always_comb begin
    next_pattern = pattern;
    next_dir     = dir;
    init_pattern = '0;
    unique case (mode_t'(mode))
      M_OFF: begin
        next_pattern = '0;
      end
      M_BLINK: begin
        next_pattern = pattern ^ BLINK_MASK;
      end
      M_CHASE: begin
        next_pattern = (pattern << 1) | (pattern >> (NUM_LEDS - 1));
        init_pattern = ONE_HOT0;
      end
      M_BOUNCE: begin
        init_pattern = ONE_HOT0;
        if (NUM_LEDS > 1) begin
          if (!dir) begin
            next_pattern = pattern << 1;
            if (next_pattern[NUM_LEDS-1]) next_dir = 1'b1;
          end else begin
            next_pattern = pattern >> 1;
            if (next_pattern[0]) next_dir = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      mode      <= RESET_MODE;
      speed     <= '0;
      step_cnt  <= '0;
      prescaler <= '0;
      dir       <= 1'b0;
      pattern   <= '0;
`ifdef LED_PWM_EN
      bright    <= '1;
`endif
    end else begin
      unique case (state)
        RUN: begin
          prescaler <= tick ? '0 : prescaler + PRE_W'(1);
          if (cfg_valid) begin
            // a step due on the accept cycle is dropped; APPLY restarts everything
            mode  <= cfg_mode;
            speed <= cfg_speed;
`ifdef LED_PWM_EN
            bright <= cfg_bright;
`endif
            state <= APPLY;
          end else if (tick) begin
            if (step_cnt == speed) begin
              step_cnt <= '0;
              pattern  <= next_pattern;
              dir      <= next_dir;
            end else begin
              step_cnt <= step_cnt + 4'd1;
            end
          end
        end
        APPLY: begin
          prescaler <= '0;
          step_cnt  <= '0;
          dir       <= 1'b0;
          pattern   <= init_pattern;
          state     <= RUN;
        end
      endcase
    end
  end

`ifdef LED_PWM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      leds    <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      leds    <= pattern & {NUM_LEDS{pwm_cnt <= bright}};
    end
  end
`else
  assign leds = pattern;
`endif

endmodule
